// File: rtl/fifo_read_stream_pkg.sv
// Shared FIFO definitions: default entry width and the output-buffer occupancy encoding.
package fifo_read_stream_pkg;

   localparam int FIFO_BITS = 32;

   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_HALF  = 2'd1,
      OCC_FULL  = 2'd2
   } occ_e;

endpackage

// File: rtl/fifo_read_stream.sv
// Pops a read-latency-1 FIFO into a valid/ready stream through a 2-entry buffer; pop-to-valid is 2 cycles.
// Backpressure holds the head word stable and stops pops once buffered plus in-flight words would exceed two.
module fifo_read_stream
   import fifo_read_stream_pkg::*;
#(
   parameter int BITS       = FIFO_BITS,
   parameter int COUNT_BITS = 32
) (
   input  logic                  read_clk,
   input  logic                  read_rst_n,
   input  logic                  p_enable,
   output logic                  p_fifo_read_en,
   input  logic                  p_fifo_read_empty,
   input  logic [BITS-1:0]       p_fifo_read_data,
   output logic                  p_out_valid,
   input  logic                  p_out_ready,
   output logic [BITS-1:0]       p_out_data,
   output logic [COUNT_BITS-1:0] p_xfer_count
);

   occ_e                  occ_q, occ_d;
   logic                  inflight_q, inflight_d;
   logic [BITS-1:0]       head_q, head_d;
   logic [BITS-1:0]       tail_q, tail_d;
   logic [COUNT_BITS-1:0] count_q, count_d;
   logic                  xfer;
   logic [2:0]            pending;

   always_comb begin
      xfer    = (occ_q != OCC_EMPTY) && p_out_ready;
      pending = {1'b0, occ_q} + {2'b00, inflight_q};
      // occupancy + inflight - transfer <= 1, rearranged to avoid unsigned underflow
      p_fifo_read_en = read_rst_n && p_enable && !p_fifo_read_empty &&
                       (pending <= ({2'b00, xfer} + 3'd1));
      inflight_d = p_fifo_read_en && !p_fifo_read_empty;
      count_d    = count_q + {{(COUNT_BITS-1){1'b0}}, xfer};

      occ_d  = occ_q;
      head_d = head_q;
      tail_d = tail_q;
      case (occ_q)
         OCC_EMPTY: begin
            if (inflight_q) begin
               occ_d  = OCC_HALF;
               head_d = p_fifo_read_data;
            end
         end
         OCC_HALF: begin
            if (inflight_q && !xfer) begin
               occ_d  = OCC_FULL;
               tail_d = p_fifo_read_data;
            end else if (inflight_q && xfer) begin
               head_d = p_fifo_read_data;
            end else if (xfer) begin
               occ_d = OCC_EMPTY;
            end
         end
         OCC_FULL: begin
            if (xfer) begin
               head_d = tail_q;
               if (inflight_q) tail_d = p_fifo_read_data;
               else            occ_d  = OCC_HALF;
            end
         end
         default: occ_d = OCC_EMPTY;
      endcase
   end

   always_ff @(posedge read_clk or negedge read_rst_n) begin
      if (!read_rst_n) begin
         occ_q      <= OCC_EMPTY;
         inflight_q <= 1'b0;
         count_q    <= '0;
      end else begin
         occ_q      <= occ_d;
         inflight_q <= inflight_d;
         count_q    <= count_d;
      end
   end

   // Data entries carry no reset; the head is only observed while occupancy is non-empty.
   always_ff @(posedge read_clk) begin
      head_q <= head_d;
      tail_q <= tail_d;
   end

   assign p_out_valid  = (occ_q != OCC_EMPTY);
   assign p_out_data   = head_q;
   assign p_xfer_count = count_q;

   a_full_no_capture: assert property (@(posedge read_clk) disable iff (!read_rst_n)
      !(occ_q == OCC_FULL && inflight_q && !xfer));

   a_no_pop_when_empty: assert property (@(posedge read_clk) disable iff (!read_rst_n)
      !(p_fifo_read_en && p_fifo_read_empty));

endmodule
